// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache sitting between the CPU fetch port
// and a slow word-wide backing memory. Hits return the word combinationally;
// misses stall the CPU while the whole line is refilled over a req/ack handshake.
module inst_cache #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [31:0] pc,
  output logic [31:0] inst,
  output logic        stall,
  input  logic        flushAll,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic [31:0] memRdata,
  input  logic        memAck
);

  localparam int WB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(LINES);
  localparam int OB = WB + 2;
  localparam int TB = 32 - OB - IB;
  localparam logic [WB-1:0] LAST_WORD = WB'(LINE_WORDS - 1);

  typedef enum logic {
    IDLE,
    REFILL
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [LINES-1:0] r_valid;
  logic [TB-1:0]    r_tag  [LINES];
  logic [31:0]      r_data [LINES][LINE_WORDS];
  logic [31:0]      r_refillBase;
  logic [WB-1:0]    r_cnt;
  logic             r_discard;

  logic [IB-1:0] w_idx;
  logic [WB-1:0] w_off;
  logic [TB-1:0] w_pcTag;
  logic [IB-1:0] w_refIdx;
  logic          w_hit;
  logic          w_wordAck;
  logic          w_lastAck;

  assign w_idx     = pc[OB+IB-1:OB];
  assign w_off     = pc[OB-1:2];
  assign w_pcTag   = pc[31:OB+IB];
  assign w_refIdx  = r_refillBase[OB+IB-1:OB];
  assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_pcTag);
  assign w_wordAck = (r_state == REFILL) && memAck;
  assign w_lastAck = w_wordAck && (r_cnt == LAST_WORD);

  // Next-state and output decode: lookup in IDLE, drive the memory request in REFILL.
  always_comb begin
    w_nextState = r_state;
    stall       = 1'b1;
    memReq      = 1'b0;
    memAddr     = 32'h0;
    inst        = w_hit ? r_data[w_idx][w_off] : 32'h0;
    case (r_state)
      IDLE: begin
        stall = !w_hit;
        if (!w_hit) w_nextState = REFILL;
      end
      REFILL: begin
        memReq  = 1'b1;
        memAddr = r_refillBase + {{(30-WB){1'b0}}, r_cnt, 2'b00};
        if (w_lastAck) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // FSM state, refill base latch, word counter and the discard flag for flushed refills.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_refillBase <= '0;
      r_discard    <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (r_state == IDLE) begin
        r_cnt <= '0;
        if (!w_hit) r_refillBase <= {pc[31:OB], {OB{1'b0}}};
      end else if (w_lastAck) begin
        r_cnt <= '0;
      end else if (w_wordAck) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_lastAck) begin
        r_discard <= 1'b0;
      end else if ((r_state == REFILL) && flushAll) begin
        r_discard <= 1'b1;
      end
    end
  end

  // Valid bits: flush always wins over validating a freshly refilled line.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_valid <= '0;
    end else if (flushAll) begin
      r_valid <= '0;
    end else if (w_lastAck && !r_discard) begin
      r_valid[w_refIdx] <= 1'b1;
    end
  end

  // Line data and tag storage, written as each refill word is acknowledged.
  always_ff @(posedge clk) begin
    if (w_wordAck) begin
      r_data[w_refIdx][r_cnt] <= memRdata;
      if (w_lastAck) r_tag[w_refIdx] <= r_refillBase[31:OB+IB];
    end
  end

endmodule

// File: tb/tb_inst_cache.sv
// Scoreboard bench for inst_cache: stimulus queues expected instructions and
// refill addresses; a monitor and a memory model pop and compare them.
module tb_inst_cache;

  logic        clk      = 1'b0;
  logic        resetN   = 1'b0;
  logic [31:0] pc       = 32'h0040_0000;
  logic [31:0] inst;
  logic        stall;
  logic        flushAll = 1'b0;
  logic        memReq;
  logic [31:0] memAddr;
  logic [31:0] memRdata = 32'h0;
  logic        memAck   = 1'b0;

  int errors = 0;
  int checks = 0;
  int maxLat = 0;

  logic [31:0] expInst[$];
  logic [31:0] expAddr[$];

  bit          waiting  = 1'b0;
  int          waitCnt  = 0;
  logic [31:0] holdAddr = 32'h0;

  inst_cache #(.LINES(16), .LINE_WORDS(4)) dut (
    .clk      (clk),
    .resetN   (resetN),
    .pc       (pc),
    .inst     (inst),
    .stall    (stall),
    .flushAll (flushAll),
    .memReq   (memReq),
    .memAddr  (memAddr),
    .memRdata (memRdata),
    .memAck   (memAck)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Backing memory contents: upper half is the address, lower half its inverse.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic pushLine(input logic [31:0] base);
    for (int w = 0; w < 4; w++) expAddr.push_back(base + 32'(w * 4));
  endtask

  // Memory model: answers each request after 0..maxLat cycles and checks the address order.
  always @(negedge clk) begin
    memAck = 1'b0;
    if (resetN && memReq) begin
      if (!waiting) begin
        waiting  = 1'b1;
        holdAddr = memAddr;
        waitCnt  = (maxLat > 0) ? int'($urandom_range(0, maxLat)) : 0;
      end else begin
        checkOutput("addrStable", memAddr, holdAddr);
      end
      if (waitCnt == 0) begin
        memAck   = 1'b1;
        memRdata = memWord(memAddr);
        waiting  = 1'b0;
        if (expAddr.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpectedReq: got 0x%08h, expected no request", memAddr);
        end else begin
          checkOutput("memAddr", memAddr, expAddr.pop_front());
        end
      end else begin
        waitCnt--;
      end
    end else begin
      waiting = 1'b0;
    end
  end

  // Output monitor: every cycle presenting a valid instruction is matched to the scoreboard.
  always @(negedge clk) begin
    if (resetN && !stall && expInst.size() != 0) checkOutput("inst", inst, expInst.pop_front());
  end

  // One fetch: drive pc, count stall cycles, optionally pulse flushAll at a given cycle.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] expWord,
                               input int expStalls, input int flushCycle, input int lat);
    int stalls = 0;
    int cyc    = 0;
    bit sawReq = 1'b0;
    bit done   = 1'b0;
    maxLat = lat;
    pc     = addr;
    expInst.push_back(expWord);
    while (!done && cyc < 300) begin
      flushAll = (cyc == flushCycle);
      @(negedge clk);
      if (memReq) sawReq = 1'b1;
      if (!stall) done = 1'b1;
      else stalls++;
      @(posedge clk);
      #1;
      cyc++;
    end
    flushAll = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL fetchTimeout: pc 0x%08h still stalled after %0d cycles, expected a hit", addr, cyc);
      expInst.delete();
      expAddr.delete();
    end else if (expStalls >= 0) begin
      checkOutput("stallCycles", 32'(stalls), 32'(expStalls));
    end else begin
      checkOutput("minStalls", 32'(stalls >= 5), 32'd1);
    end
    if (expStalls == 0) checkOutput("noReqOnHit", 32'(sawReq), 32'd0);
    checkOutput("addrQueueDrained", 32'(expAddr.size()), 32'd0);
  endtask

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence.
  initial begin
    #2;
    checkOutput("resetStall", 32'(stall), 32'd1);
    checkOutput("resetInst", inst, 32'h0);
    checkOutput("resetMemReq", 32'(memReq), 32'd0);
    checkOutput("resetMemAddr", memAddr, 32'h0);
    @(posedge clk);
    pushLine(32'h0040_0000);
    @(posedge clk);
    #1;
    resetN = 1'b1;

    $display("[TB] cold miss");
    applyStimulus(32'h0040_0000, 32'h0000_FFFF, 5, -1, 0);

    $display("[TB] hits in the same line");
    applyStimulus(32'h0040_000C, 32'h000C_FFF3, 0, -1, 0);
    applyStimulus(32'h0040_0004, 32'h0004_FFFB, 0, -1, 0);

    $display("[TB] conflict eviction");
    pushLine(32'h0040_0100);
    applyStimulus(32'h0040_0100, 32'h0100_FEFF, 5, -1, 0);
    pushLine(32'h0040_0000);
    applyStimulus(32'h0040_0000, 32'h0000_FFFF, 5, -1, 0);

    $display("[TB] variable ack latency");
    pushLine(32'h0040_0030);
    applyStimulus(32'h0040_0038, 32'h0038_FFC7, -1, -1, 5);
    applyStimulus(32'h0040_0030, 32'h0030_FFCF, 0, -1, 0);
    applyStimulus(32'h0040_003C, 32'h003C_FFC3, 0, -1, 0);

    $display("[TB] flush during refill at word 2");
    pushLine(32'h0040_0040);
    pushLine(32'h0040_0040);
    applyStimulus(32'h0040_0040, 32'h0040_FFBF, 10, 3, 0);
    pushLine(32'h0040_0030);
    applyStimulus(32'h0040_003C, 32'h003C_FFC3, 5, -1, 0);

    $display("[TB] flush coinciding with the final ack");
    pushLine(32'h0040_0050);
    pushLine(32'h0040_0050);
    applyStimulus(32'h0040_0058, 32'h0058_FFA7, 10, 4, 0);
    applyStimulus(32'h0040_0050, 32'h0050_FFAF, 0, -1, 0);

    $display("[TB] flush in idle");
    flushAll = 1'b1;
    @(posedge clk);
    #1;
    flushAll = 1'b0;
    pushLine(32'h0040_0050);
    applyStimulus(32'h0040_0050, 32'h0050_FFAF, 5, -1, 0);

    $display("[TB] reset in the middle of a refill");
    pc = 32'h0040_0208;
    expAddr.push_back(32'h0040_0200);
    expAddr.push_back(32'h0040_0204);
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    @(posedge clk);
    #1;
    checkOutput("midRefillReq", 32'(memReq), 32'd1);
    checkOutput("midRefillAddr", memAddr, 32'h0040_0208);
    resetN = 1'b0;
    #1;
    checkOutput("asyncResetReq", 32'(memReq), 32'd0);
    checkOutput("asyncResetStall", 32'(stall), 32'd1);
    checkOutput("asyncResetInst", inst, 32'h0);
    checkOutput("partialAddrDrained", 32'(expAddr.size()), 32'd0);
    @(posedge clk);
    pushLine(32'h0040_0200);
    @(posedge clk);
    #1;
    resetN = 1'b1;
    applyStimulus(32'h0040_0208, 32'h0208_FDF7, 5, -1, 0);

    repeat (3) @(posedge clk);
    checkOutput("instQueueEmpty", 32'(expInst.size()), 32'd0);
    checkOutput("addrQueueEmpty", 32'(expAddr.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
